// File: rtl/oled_page_writer.sv
// Streams a frame buffer to an SSD1306-class OLED as per-page I2C command + data transactions.
// Optional checkerboard test pattern source: define OLED_PAGE_WRITER_PATTERN_EN.
`timescale 1ns/1ps
module oled_page_writer #(
  parameter int          PAGES      = 8,
  parameter int          COLS       = 128,
  parameter int          COL_OFFSET = 0,
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
`ifdef OLED_PAGE_WRITER_PATTERN_EN
  input  logic       pattern_sel,
`endif
  output logic       busy,
  output logic       done,
  output logic       fb_rd_en,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_first,
  output logic       tx_last
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DHDR, S_FETCH, S_SEND, S_DONE} state_t;

  localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);
  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [9:0] COLS_W    = 10'(COLS);
  localparam logic [6:0] OFF       = 7'(COL_OFFSET);
  localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  state_t     state_q, state_d;
  logic [2:0] page_q, page_d;
  logic [6:0] col_q, col_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       fresh_q, fresh_d;
  logic       pat_on;

`ifdef OLED_PAGE_WRITER_PATTERN_EN
  logic pat_q, pat_d;

  always_comb pat_d = (state_q == S_IDLE && start) ? pattern_sel : pat_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pat_q <= 1'b0;
    else     pat_q <= pat_d;
  end

  assign pat_on = pat_q;
`else
  assign pat_on = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      fresh_q <= fresh_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    col_d    = col_q;
    idx_d    = idx_q;
    data_d   = data_q;
    fresh_d  = fresh_q;
    busy     = 1'b0;
    done     = 1'b0;
    fb_rd_en = 1'b0;
    fb_addr  = '0;
    tx_valid = 1'b0;
    tx_byte  = '0;
    tx_first = 1'b0;
    tx_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          page_d  = '0;
          col_d   = '0;
          idx_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        case (idx_q)
          3'd0: begin tx_byte = ADDR_BYTE; tx_first = 1'b1; end
          3'd1: tx_byte = 8'h00;
          3'd2: tx_byte = 8'hB0 | {5'd0, page_q};
          3'd3: tx_byte = {4'h0, OFF[3:0]};
          default: begin tx_byte = {5'b00010, OFF[6:4]}; tx_last = 1'b1; end
        endcase
        if (tx_ready) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = S_DHDR;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_DHDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_first = (idx_q == 3'd0);
        tx_byte  = (idx_q == 3'd0) ? ADDR_BYTE : 8'h40;
        if (tx_ready) begin
          if (idx_q == 3'd0) begin
            idx_d = 3'd1;
          end else begin
            idx_d   = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        fb_rd_en = !pat_on;
        fb_addr  = 10'(page_q) * COLS_W + 10'(col_q);
        fresh_d  = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        // RAM data is only valid in the first SEND cycle; hold it for stalls.
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_last  = (col_q == COL_LAST);
        if (pat_on)       tx_byte = (col_q[3] ^ page_q[0]) ? 8'hFF : 8'h00;
        else if (fresh_q) tx_byte = fb_data;
        else              tx_byte = data_q;
        if (fresh_q) data_d = fb_data;
        fresh_d = 1'b0;
        if (tx_ready) begin
          if (col_q != COL_LAST) begin
            col_d   = col_q + 7'd1;
            state_d = S_FETCH;
          end else if (page_q != PAGE_LAST) begin
            page_d  = page_q + 3'd1;
            col_d   = '0;
            state_d = S_CMD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oled_page_writer.sv
// Bench for oled_page_writer: a default-size and a small (2x4, offset 0x25) instance checked
// every cycle against a byte-queue model of the frame; pattern checks when the macro is defined.
`timescale 1ns/1ps
module tb_oled_page_writer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  always #5 CLK = ~CLK;

  logic       start [2];
  logic       tx_ready [2];
  logic       busy [2], done [2], fb_rd_en [2];
  logic       tx_valid [2], tx_first [2], tx_last [2];
  logic [9:0] fb_addr [2];
  logic [7:0] fb_data [2], tx_byte [2];
  logic [7:0] mem [2][1024];
`ifdef OLED_PAGE_WRITER_PATTERN_EN
  logic       pattern_sel = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit rnd_mode = 1'b0;

  typedef struct {
    bit         imm;
    bit         first;
    bit         last;
    logic [7:0] b;
    int         addr;
  } ent_t;

  oled_page_writer u_big (
    .CLK(CLK), .RST(RST), .start(start[0]),
`ifdef OLED_PAGE_WRITER_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .busy(busy[0]), .done(done[0]), .fb_rd_en(fb_rd_en[0]), .fb_addr(fb_addr[0]),
    .fb_data(fb_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .tx_byte(tx_byte[0]), .tx_first(tx_first[0]), .tx_last(tx_last[0]));

  oled_page_writer #(.PAGES(2), .COLS(4), .COL_OFFSET(37)) u_small (
    .CLK(CLK), .RST(RST), .start(start[1]),
`ifdef OLED_PAGE_WRITER_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .busy(busy[1]), .done(done[1]), .fb_rd_en(fb_rd_en[1]), .fb_addr(fb_addr[1]),
    .fb_data(fb_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .tx_byte(tx_byte[1]), .tx_first(tx_first[1]), .tx_last(tx_last[1]));

  // Synchronous frame-buffer RAM: data valid the cycle after the read strobe.
  always @(posedge CLK)
    for (int k = 0; k < 2; k++)
      if (fb_rd_en[k]) fb_data[k] <= mem[k][fb_addr[k]];

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int outs(input int k);
    return int'({busy[k], done[k], fb_rd_en[k], fb_addr[k], tx_valid[k],
                 tx_byte[k], tx_first[k], tx_last[k]});
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int P   = (g == 0) ? 8 : 2;
    localparam int C   = (g == 0) ? 128 : 4;
    localparam int OFF = (g == 0) ? 0 : 37;

    ent_t       q[$];
    logic [7:0] log_b[$];
    bit         active = 0, done_cyc = 0, chk_next = 0, exp_v = 0, exp_rd = 0;
    bit         stall = 0, pat = 0;
    logic [9:0] stall_v = '0;
    int         dcount = 0;

    function automatic void add(input bit imm, input bit f, input bit l,
                                input logic [7:0] b, input int a);
      ent_t e;
      e.imm = imm; e.first = f; e.last = l; e.b = b; e.addr = a;
      q.push_back(e);
    endfunction

    function automatic void build();
      q.delete();
      for (int p = 0; p < P; p++) begin
        add(1, 1, 0, 8'h78, 0);
        add(1, 0, 0, 8'h00, 0);
        add(1, 0, 0, 8'hB0 | 8'(p), 0);
        add(1, 0, 0, 8'(OFF % 16), 0);
        add(1, 0, 1, 8'h10 | 8'(OFF / 16), 0);
        add(1, 1, 0, 8'h78, 0);
        add(0, 0, 0, 8'h40, 0);
        for (int c = 0; c < C; c++) begin
          int a;
          logic [7:0] b;
          a = p * C + c;
          if (pat) b = ((((c / 8) ^ p) % 2) != 0) ? 8'hFF : 8'h00;
          else     b = mem[g][a];
          add((c == C - 1) && (p < P - 1), 0, c == C - 1, b, a);
        end
      end
    endfunction

    always @(negedge CLK) begin
      ent_t e;
      bit   next_done;
      if (RST) begin
        active = 0; done_cyc = 0; chk_next = 0; stall = 0;
        q.delete();
      end else begin
        chk(busy[g] == active, "busy", int'(busy[g]), int'(active));
        chk(done[g] == done_cyc, "done", int'(done[g]), int'(done_cyc));
        if (done[g]) dcount++;
        if (!active) chk(tx_valid[g] == 1'b0, "valid_idle", int'(tx_valid[g]), 0);
        if (chk_next) begin
          chk(tx_valid[g] == exp_v, "valid_timing", int'(tx_valid[g]), int'(exp_v));
          chk(fb_rd_en[g] == exp_rd, "rd_en_timing", int'(fb_rd_en[g]), int'(exp_rd));
          if (exp_rd && q.size() > 0)
            chk(int'(fb_addr[g]) == q[0].addr, "fb_addr", int'(fb_addr[g]), q[0].addr);
        end else begin
          chk(fb_rd_en[g] == 1'b0, "rd_en_spurious", int'(fb_rd_en[g]), 0);
        end
        if (stall)
          chk(tx_valid[g] && {tx_first[g], tx_last[g], tx_byte[g]} == stall_v, "stall_stable",
              int'({tx_valid[g], tx_first[g], tx_last[g], tx_byte[g]}), int'({1'b1, stall_v}));
        next_done = 0;
        if (active && tx_valid[g] && tx_ready[g]) begin
          if (q.size() == 0) begin
            chk(0, "extra_byte", int'(tx_byte[g]), 0);
            chk_next = 0;
          end else begin
            e = q.pop_front();
            chk({tx_first[g], tx_last[g], tx_byte[g]} == {e.first, e.last, e.b}, "tx_byte",
                int'({tx_first[g], tx_last[g], tx_byte[g]}), int'({e.first, e.last, e.b}));
            log_b.push_back(tx_byte[g]);
            chk_next = 1;
            if (q.size() == 0) begin
              active = 0; next_done = 1; exp_v = 0; exp_rd = 0;
            end else begin
              exp_v = e.imm; exp_rd = !e.imm && !pat;
            end
          end
        end else if (!active && !done_cyc && start[g]) begin
`ifdef OLED_PAGE_WRITER_PATTERN_EN
          pat = (g == 0) ? pattern_sel : 1'b0;
`else
          pat = 0;
`endif
          build();
          log_b.delete();
          active = 1; chk_next = 1; exp_v = 1; exp_rd = 0;
        end else begin
          chk_next = 0;
        end
        stall    = tx_valid[g] && !tx_ready[g];
        stall_v  = {tx_first[g], tx_last[g], tx_byte[g]};
        done_cyc = next_done;
      end
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    if (rnd_mode)
      for (int k = 0; k < 2; k++) begin
        tx_ready[k] = ($urandom_range(0, 9) < 3);
        start[k]    = ($urandom_range(0, 39) == 0) || done[k];
      end
  end

  task automatic wait_idle(input int lim, input string nm);
    int c;
    c = 0;
    while ((busy[0] || done[0] || busy[1] || done[1]) && c < lim) begin
      @(posedge CLK); #1;
      c++;
    end
    chk(c < lim, nm, c, lim);
  endtask

  initial begin
    logic [7:0] exp_small [22];
    int         found, d0;
    exp_small = '{8'h78, 8'h00, 8'hB0, 8'h05, 8'h12, 8'h78, 8'h40, 8'h00, 8'h01, 8'h02, 8'h03,
                  8'h78, 8'h00, 8'hB1, 8'h05, 8'h12, 8'h78, 8'h40, 8'h04, 8'h05, 8'h06, 8'h07};
    for (int i = 0; i < 1024; i++) begin
      mem[0][i] = 8'($urandom);
      mem[1][i] = 8'(i);
    end
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      tx_ready[k] = 1'b1;
    end
    repeat (3) @(posedge CLK);
    #1;
    chk(outs(0) == 0, "reset_outs_big", outs(0), 0);
    chk(outs(1) == 0, "reset_outs_small", outs(1), 0);
    RST = 1'b0;

    // Full frame with tx_ready=1; start pulses during busy and the DONE cycle must be ignored.
    @(posedge CLK); #1;
    start[0] = 1'b1; start[1] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0; start[1] = 1'b0;
    found = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK); #1;
      start[0] = (busy[0] && (c % 97 == 0)) || done[0];
      start[1] = (busy[1] && (c % 5 == 0)) || done[1];
      if (g_ch[0].dcount >= 1 && g_ch[1].dcount >= 1 &&
          !busy[0] && !done[0] && !busy[1] && !done[1]) begin
        found = 1;
        break;
      end
    end
    chk(found == 1, "frame1_timeout", found, 1);
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk(g_ch[0].dcount == 1, "done_count_big", g_ch[0].dcount, 1);
    chk(g_ch[1].dcount == 1, "done_count_small", g_ch[1].dcount, 1);
    chk(g_ch[0].log_b.size() == 1080, "hs_count_big", g_ch[0].log_b.size(), 1080);
    chk(g_ch[1].log_b.size() == 22, "hs_count_small", g_ch[1].log_b.size(), 22);
    if (g_ch[1].log_b.size() == 22)
      for (int i = 0; i < 22; i++)
        chk(g_ch[1].log_b[i] == exp_small[i], "small_seq", int'(g_ch[1].log_b[i]),
            int'(exp_small[i]));
    if (g_ch[0].log_b.size() >= 7) begin
      chk(g_ch[0].log_b[0] == 8'h78, "big_b0", int'(g_ch[0].log_b[0]), 'h78);
      chk(g_ch[0].log_b[2] == 8'hB0, "big_b2", int'(g_ch[0].log_b[2]), 'hB0);
      chk(g_ch[0].log_b[4] == 8'h10, "big_b4", int'(g_ch[0].log_b[4]), 'h10);
      chk(g_ch[0].log_b[6] == 8'h40, "big_b6", int'(g_ch[0].log_b[6]), 'h40);
    end

    // Random backpressure and random start pulses.
    d0 = g_ch[1].dcount;
    rnd_mode = 1'b1;
    repeat (9000) @(posedge CLK);
    rnd_mode = 1'b0;
    @(posedge CLK); #1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      tx_ready[k] = 1'b1;
    end
    wait_idle(6000, "random_idle_timeout");
    chk(g_ch[1].dcount > d0 + 1, "random_frames", g_ch[1].dcount - d0, 2);

    // Reset in the middle of page 3, then restart from page 0.
    @(posedge CLK); #1;
    start[0] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      if (fb_rd_en[0] && fb_addr[0] == 10'd389) begin
        found = 1;
        break;
      end
    end
    chk(found == 1, "page3_reach", found, 1);
    #2 RST = 1'b1;
    #1;
    chk(outs(0) == 0, "midframe_reset_big", outs(0), 0);
    chk(outs(1) == 0, "midframe_reset_small", outs(1), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    start[0] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0;
    wait_idle(3000, "restart_timeout");
    chk(g_ch[0].log_b.size() == 1080, "restart_count", g_ch[0].log_b.size(), 1080);
    if (g_ch[0].log_b.size() > 2)
      chk(g_ch[0].log_b[2] == 8'hB0, "restart_page0", int'(g_ch[0].log_b[2]), 'hB0);

`ifdef OLED_PAGE_WRITER_PATTERN_EN
    @(posedge CLK); #1;
    pattern_sel = 1'b1;
    start[0] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0;
    pattern_sel = 1'b0;
    wait_idle(3000, "pattern_timeout");
    if (g_ch[0].log_b.size() == 1080) begin
      chk(g_ch[0].log_b[7] == 8'h00, "pat_p0c0", int'(g_ch[0].log_b[7]), 'h00);
      chk(g_ch[0].log_b[15] == 8'hFF, "pat_p0c8", int'(g_ch[0].log_b[15]), 'hFF);
      chk(g_ch[0].log_b[22] == 8'hFF, "pat_p0c15", int'(g_ch[0].log_b[22]), 'hFF);
      chk(g_ch[0].log_b[23] == 8'h00, "pat_p0c16", int'(g_ch[0].log_b[23]), 'h00);
      chk(g_ch[0].log_b[142] == 8'hFF, "pat_p1c0", int'(g_ch[0].log_b[142]), 'hFF);
      chk(g_ch[0].log_b[150] == 8'h00, "pat_p1c8", int'(g_ch[0].log_b[150]), 'h00);
    end else begin
      chk(0, "pat_count", g_ch[0].log_b.size(), 1080);
    end
`endif

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oled_page_writer.md
# oled_page_writer

Streams a full frame buffer to an SSD1306-class OLED as a sequence of I2C byte transactions, page by page. For each page it emits a command transaction that sets the page and column address, then a data transaction carrying the page's column bytes read from an external frame-buffer RAM. It sits directly upstream of the byte-level I2C master and presents bytes to it over a valid/ready handshake, with start/stop framing flags. It runs after panel init (`i2c_oled_setup`) has completed.

## Interface
- `PAGES`, 8: number of pages per frame, 1..8.
- `COLS`, 128: columns per page, 1..128; `PAGES*COLS` ≤ 1024.
- `COL_OFFSET`, 0: first column address written to the panel, 0..127.
- `SLAVE_ADDR`, 7'h3C: 7-bit panel address; the address byte is `{SLAVE_ADDR,1'b0}`.

- `CLK` in 1: system clock; all logic on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: frame request; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the frame's final byte handshake.
- `fb_rd_en` out 1: frame-buffer read strobe.
- `fb_addr` out 10: frame-buffer address, `page*COLS + col`.
- `fb_data` in 8: read data, valid exactly 1 cycle after `fb_rd_en`.
- `tx_valid` out 1: `tx_byte` is offered to the I2C master.
- `tx_ready` in 1: the master accepts the byte in the cycle where `tx_valid && tx_ready`.
- `tx_byte` out 8: byte to transmit.
- `tx_first` out 1: the master issues START before this byte.
- `tx_last` out 1: the master issues STOP after this byte.

## Operation
- States: IDLE, CMD, DHDR, FETCH, SEND, DONE.
- **IDLE**: `start`=1 clears `page`/`col`/`idx` and moves to CMD.
- **CMD** sends 5 bytes, in order: `{SLAVE_ADDR,0}` (`tx_first`=1), 0x00, `0xB0|page`, `0x00|COL_OFFSET[3:0]`, `0x10|COL_OFFSET[6:4]` (`tx_last`=1).
- **DHDR** sends 2 bytes: `{SLAVE_ADDR,0}` (`tx_first`=1), then 0x40. It then moves to FETCH.
- **FETCH**: one cycle with `fb_rd_en`=1 and `fb_addr`=`page*COLS+col`. Always moves to SEND.
- **SEND**: `tx_byte` is `fb_data` registered at SEND entry. `tx_last`=1 when `col==COLS-1`.
  - Handshake with `col<COLS-1`: `col`+1, return to FETCH.
  - Handshake on the last column with `page<PAGES-1`: `page`+1, `col`=0, go to CMD.
  - Handshake on the last column of the last page: go to DONE.
- **DONE**: one cycle with `done`=1 and `busy`=0, then IDLE.
- Handshake rules:
  - `tx_byte`, `tx_first` and `tx_last` are held stable while `tx_valid && !tx_ready`.
  - `tx_valid` never drops without a handshake.
  - `tx_valid` is 0 in IDLE, FETCH and DONE.
- `start` is ignored when not in IDLE, including in DONE. No queuing.
- `tx_ready` asserted while `tx_valid`=0 has no effect.
- Byte count per frame is `PAGES*(7+COLS)`: 1080 at defaults.
- Counters do not wrap: `page` and `col` never exceed `PAGES-1` and `COLS-1`.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-frame aborts immediately. The I2C master is responsible for its own bus recovery.
- `start` sampled high at edge N:
  - `busy`=1 and `tx_valid`=1 with the address byte from cycle N+1.
- Command and header bytes issue back-to-back: the next byte is presented in the cycle after its predecessor's handshake.
- Data bytes: minimum 2 cycles per byte (FETCH then SEND).
  - `fb_rd_en` at cycle M gives `tx_valid` at M+1.
- `done` is asserted exactly 1 cycle after the final handshake.

## Configuration
- Macro: `OLED_PAGE_WRITER_PATTERN_EN`.
- **Defined**: adds input `pattern_sel` (1 bit), sampled when `start` is accepted.
  - When the sampled value is 1, data bytes are an 8×8 checkerboard: `((col>>3)^page)&1 ? 8'hFF : 8'h00`.
  - `fb_rd_en` stays 0. FETCH and SEND timing is unchanged.
- **Undefined**: the port is absent; data always comes from `fb_data`.

## Test plan
- Reset, then a `start` pulse with `tx_ready` held at 1 → first bytes 0x78(first), 0x00, 0xB0, 0x00, 0x10(last), 0x78(first), 0x40.
  - 1080 handshakes total; `done` pulses once; `busy` returns to 0.
- Frame-buffer model returning `addr[7:0]`, `PAGES=2`, `COLS=4` → data bytes 0,1,2,3(last), then page 1 commands with 0xB1, then 4,5,6,7(last).
- `tx_ready` random 30% duty → `tx_byte`/`tx_first`/`tx_last` never change while stalled; byte sequence is identical to the `tx_ready`=1 run.
- `start` pulsed during `busy` and during the DONE cycle → ignored; exactly one `done`.
- `RST` asserted mid-data on page 3 → all outputs 0 within the same cycle. A subsequent `start` restarts from page 0 with 0xB0.
- With `OLED_PAGE_WRITER_PATTERN_EN` and `pattern_sel`=1 → page 0 cols 0–7 send 0x00, cols 8–15 send 0xFF; page 1 is inverted; `fb_rd_en` is never 1.
